// File: rtl/neighbor_fetch.sv
// 8-neighbour fetch engine for a 2-D node grid: looks up all in-bounds
// neighbours in a banked cache and refills misses one at a time from memory.
package neighbor_fetch_pkg;
  typedef logic [31:0] node_mem_t;
endpackage

module neighbor_fetch
  import neighbor_fetch_pkg::*;
#(
  parameter int X_WIDTH    = 5,
  parameter int Y_WIDTH    = 5,
  parameter int ADDR_WIDTH = X_WIDTH + Y_WIDTH,
  parameter int NUM_PORTS  = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [X_WIDTH-1:0]                   req_x,
  input  logic [Y_WIDTH-1:0]                   req_y,
  output logic [NUM_PORTS-1:0]                 cache_valid,
  output logic [NUM_PORTS-1:0]                 cache_write,
  output logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] cache_addr,
  output node_mem_t [NUM_PORTS-1:0]            cache_wdata,
  input  logic [NUM_PORTS-1:0]                 cache_hit,
  input  node_mem_t [NUM_PORTS-1:0]            cache_rdata,
  output logic                                 mem_req,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic                                 mem_ack,
  input  node_mem_t                            mem_rdata,
  output logic                                 rsp_valid,
  input  logic                                 rsp_ready,
  output logic [NUM_PORTS-1:0]                 rsp_mask,
  output node_mem_t [NUM_PORTS-1:0]            rsp_data,
  output logic [15:0]                          refill_count
);

  localparam int SW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int NS = (NUM_PORTS < 8) ? NUM_PORTS : 8;

  // Slot direction tables: bit i set when slot i steps that way.
  localparam logic [7:0] XP = 8'h0E;
  localparam logic [7:0] XM = 8'hE0;
  localparam logic [7:0] YM = 8'h83;
  localparam logic [7:0] YP = 8'h38;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_HIT,
    REFILL_REQ,
    REFILL_WAIT,
    FILL,
    RESP
  } state_t;

  state_t                               state;
  logic [NUM_PORTS-1:0]                 mask;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr;
  logic [NUM_PORTS-1:0]                 miss_vec;
  logic [SW-1:0]                        sel;

  logic [NUM_PORTS-1:0]                 nb_mask;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] nb_addr;
  logic [X_WIDTH-1:0]                   nx;
  logic [Y_WIDTH-1:0]                   ny;
  logic                                 okx;
  logic                                 oky;

  logic [NUM_PORTS-1:0]                 miss_now;
  logic [NUM_PORTS-1:0]                 sel_hot;
  logic [NUM_PORTS-1:0]                 miss_left;
  logic [SW-1:0]                        first_now;
  logic [SW-1:0]                        first_left;

  function automatic logic [SW-1:0] lowest(input logic [NUM_PORTS-1:0] v);
    logic [SW-1:0] r;
    r = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (v[i]) r = SW'(i);
    end
    return r;
  endfunction

  // Neighbour coordinates never wrap; an edge step clears the slot.
  always_comb begin
    nb_mask = '0;
    nb_addr = '0;
    nx      = req_x;
    ny      = req_y;
    okx     = 1'b0;
    oky     = 1'b0;
    for (int i = 0; i < NS; i++) begin
      nx = req_x;
      ny = req_y;
      if (XP[i]) nx = req_x + X_WIDTH'(1);
      if (XM[i]) nx = req_x - X_WIDTH'(1);
      if (YP[i]) ny = req_y + Y_WIDTH'(1);
      if (YM[i]) ny = req_y - Y_WIDTH'(1);
      okx = !(XP[i] && (&req_x)) && !(XM[i] && (req_x == '0));
      oky = !(YP[i] && (&req_y)) && !(YM[i] && (req_y == '0));
      nb_mask[i] = okx && oky;
      nb_addr[i] = ADDR_WIDTH'({ny, nx});
    end
  end

  assign miss_now   = mask & ~cache_hit;
  assign sel_hot    = NUM_PORTS'(1) << sel;
  assign miss_left  = miss_vec & ~sel_hot;
  assign first_now  = lowest(miss_now);
  assign first_left = lowest(miss_left);
  assign cache_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      req_ready    <= 1'b0;
      mask         <= '0;
      addr         <= '0;
      miss_vec     <= '0;
      sel          <= '0;
      cache_valid  <= '0;
      cache_write  <= '0;
      cache_wdata  <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      rsp_valid    <= 1'b0;
      rsp_mask     <= '0;
      rsp_data     <= '0;
      refill_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready   <= 1'b0;
            mask        <= nb_mask;
            addr        <= nb_addr;
            cache_valid <= nb_mask;
            cache_write <= '0;
            miss_vec    <= '0;
            rsp_mask    <= '0;
            rsp_data    <= '0;
            state       <= LOOKUP;
          end
        end
        LOOKUP: begin
          cache_valid <= '0;
          state       <= WAIT_HIT;
        end
        WAIT_HIT: begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (mask[i] && cache_hit[i]) rsp_data[i] <= cache_rdata[i];
          end
          miss_vec <= miss_now;
          if (miss_now == '0) begin
            rsp_valid <= 1'b1;
            rsp_mask  <= mask;
            state     <= RESP;
          end else begin
            sel      <= first_now;
            mem_addr <= addr[first_now];
            mem_req  <= 1'b1;
            state    <= REFILL_REQ;
          end
        end
        REFILL_REQ, REFILL_WAIT: begin
          if (mem_ack) begin
            mem_req          <= 1'b0;
            rsp_data[sel]    <= mem_rdata;
            cache_valid      <= sel_hot;
            cache_write      <= sel_hot;
            cache_wdata[sel] <= mem_rdata;
            state            <= FILL;
          end else begin
            state <= REFILL_WAIT;
          end
        end
        FILL: begin
          cache_valid <= '0;
          cache_write <= '0;
          cache_wdata <= '0;
          miss_vec    <= miss_left;
          if (refill_count != 16'hFFFF) begin
            refill_count <= refill_count + 16'd1;
          end
          if (miss_left != '0) begin
            sel      <= first_left;
            mem_addr <= addr[first_left];
            mem_req  <= 1'b1;
            state    <= REFILL_REQ;
          end else begin
            rsp_valid <= 1'b1;
            rsp_mask  <= mask;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neighbor_fetch.sv
// Self-checking bench for neighbor_fetch: grid-geometry reference model,
// behavioural cache and latency-programmable memory.
module tb_neighbor_fetch;
  import neighbor_fetch_pkg::*;

  typedef struct packed {
    logic [7:0] cv;
    logic [7:0] cw;
    logic [9:0] a;
    node_mem_t  d;
  } fill_t;

  localparam int DX[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  localparam int DY[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [4:0] req_x = '0;
  logic [4:0] req_y = '0;
  logic [7:0] cache_valid;
  logic [7:0] cache_write;
  logic [7:0][9:0] cache_addr;
  node_mem_t [7:0] cache_wdata;
  logic [7:0] cache_hit;
  node_mem_t [7:0] cache_rdata;
  logic mem_req;
  logic [9:0] mem_addr;
  logic mem_ack = 1'b0;
  node_mem_t mem_rdata = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b0;
  logic [7:0] rsp_mask;
  node_mem_t [7:0] rsp_data;
  logic [15:0] refill_count;

  int total = 0;
  int bad = 0;
  logic [7:0] hit_pat = 8'hFF;
  int mem_lat = 1;
  bit spur = 1'b0;
  int req_cnt = 0;
  int mem_cycles = 0;
  int addr_bad = 0;
  logic prev_req = 1'b0;
  logic [9:0] prev_addr = '0;
  fill_t fill_q[$];
  logic [9:0] addr_log[$];

  logic [7:0] exp_mask;
  node_mem_t [7:0] exp_data;
  fill_t exp_fills[$];
  logic [9:0] exp_maddr[$];
  int exp_count = 0;

  always #5 clk = ~clk;

  neighbor_fetch dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .cache_valid(cache_valid), .cache_write(cache_write),
    .cache_addr(cache_addr), .cache_wdata(cache_wdata),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_mask(rsp_mask), .rsp_data(rsp_data),
    .refill_count(refill_count)
  );

  function automatic node_mem_t node_val(input logic [9:0] a);
    return {6'h2B, a, ~a, 6'h15};
  endfunction

  // Cache: hits return the node value, misses return junk.
  assign cache_hit = hit_pat;
  always_comb begin
    cache_rdata = '0;
    for (int i = 0; i < 8; i++) begin
      cache_rdata[i] = hit_pat[i] ? node_val(cache_addr[i])
                                  : (32'hDEAD_0000 | 32'(i));
    end
  end

  // Memory model and fill monitor.
  always @(negedge clk) begin
    if (mem_req && prev_req && mem_addr !== prev_addr) addr_bad++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    if (|cache_write) begin
      for (int k = 0; k < 8; k++) begin
        if (cache_write[k]) begin
          fill_q.push_back('{cv: cache_valid, cw: cache_write,
                             a: cache_addr[k], d: cache_wdata[k]});
        end
      end
    end
    if (mem_req) begin
      mem_cycles++;
      req_cnt++;
      if (req_cnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = node_val(mem_addr);
        addr_log.push_back(mem_addr);
      end else begin
        mem_ack = 1'b0;
      end
    end else begin
      req_cnt   = 0;
      mem_ack   = spur && ($urandom_range(0, 1) == 1);
      mem_rdata = 32'hBAD0_BAD0;
    end
  end

  task automatic model(input int x, input int y);
    exp_mask = '0;
    exp_data = '0;
    exp_fills.delete();
    exp_maddr.delete();
    for (int s = 0; s < 8; s++) begin
      int nx;
      int ny;
      logic [9:0] a;
      nx = x + DX[s];
      ny = y + DY[s];
      if (nx >= 0 && nx < 32 && ny >= 0 && ny < 32) begin
        a = 10'(ny * 32 + nx);
        exp_mask[s] = 1'b1;
        exp_data[s] = node_val(a);
        if (!hit_pat[s]) begin
          exp_fills.push_back('{cv: 8'(1 << s), cw: 8'(1 << s),
                                a: a, d: node_val(a)});
          exp_maddr.push_back(a);
        end
      end
    end
  endtask

  task automatic do_req(input int x, input int y,
                        output int lat, output logic [7:0] lk_cv);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL req_ready_wait got=%b want=1", req_ready);
    end
    req_x = 5'(x);
    req_y = 5'(y);
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lk_cv = '0;
    for (n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) lk_cv = cache_valid;
      if (rsp_valid) break;
    end
    lat = n;
    if (lat > 300) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout got=%0d want<=300", lat);
    end
  endtask

  task automatic finish_rsp();
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
    total++;
    if ({rsp_valid, mem_req} !== 2'b00) begin bad++; $display("FAIL rst_valid_req got=%b want=00", {rsp_valid, mem_req}); end
    total++;
    if ({cache_valid, cache_write} !== 16'h0) begin bad++; $display("FAIL rst_cache got=%h want=0", {cache_valid, cache_write}); end
    total++;
    if (rsp_mask !== 8'h00) begin bad++; $display("FAIL rst_mask got=%h want=00", rsp_mask); end
    total++;
    if (rsp_data !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", rsp_data); end
    total++;
    if (refill_count !== 16'h0) begin bad++; $display("FAIL rst_count got=%h want=0", refill_count); end
    rst = 1'b0;
    exp_count = 0;
    for (int n = 0; n < 5 && !req_ready; n++) @(negedge clk);
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_all_hit();
    int lat;
    int mc;
    logic [7:0] cv;
    hit_pat = 8'hFF;
    mc = mem_cycles;
    model(5, 5);
    do_req(5, 5, lat, cv);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL hit_latency got=%0d want=3", lat); end
    total++;
    if (cv !== exp_mask) begin bad++; $display("FAIL hit_lookup_cv got=%h want=%h", cv, exp_mask); end
    total++;
    if (rsp_mask !== 8'hFF) begin bad++; $display("FAIL hit_mask got=%h want=ff", rsp_mask); end
    total++;
    if (rsp_data !== exp_data) begin bad++; $display("FAIL hit_data got=%h want=%h", rsp_data, exp_data); end
    total++;
    if (refill_count !== 16'(exp_count)) begin bad++; $display("FAIL hit_count got=%0d want=%0d", refill_count, exp_count); end
    total++;
    if (mem_cycles !== mc) begin bad++; $display("FAIL hit_mem_req got=%0d want=%0d", mem_cycles, mc); end
    total++;
    if ({cache_valid, cache_write} !== 16'h0) begin bad++; $display("FAIL hit_resp_cache got=%h want=0", {cache_valid, cache_write}); end
    finish_rsp();
  endtask

  task automatic test_corners();
    int cx[2] = '{0, 31};
    logic [7:0] cm[2] = '{8'h1C, 8'hC1};
    int lat;
    logic [7:0] cv;
    hit_pat = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      model(cx[i], cx[i]);
      do_req(cx[i], cx[i], lat, cv);
      total++;
      if (cv !== cm[i]) begin bad++; $display("FAIL corner_lookup_cv got=%h want=%h", cv, cm[i]); end
      total++;
      if (rsp_mask !== cm[i]) begin bad++; $display("FAIL corner_mask got=%h want=%h", rsp_mask, cm[i]); end
      total++;
      if (rsp_data !== exp_data) begin bad++; $display("FAIL corner_data got=%h want=%h", rsp_data, exp_data); end
      total++;
      if (lat !== 3) begin bad++; $display("FAIL corner_latency got=%0d want=3", lat); end
      finish_rsp();
    end
  endtask

  task automatic test_refill();
    int lat;
    int fb;
    int ab;
    int bb;
    logic [7:0] cv;
    hit_pat = 8'hDD;
    mem_lat = 3;
    fb = fill_q.size();
    ab = addr_log.size();
    bb = addr_bad;
    model(5, 5);
    do_req(5, 5, lat, cv);
    exp_count += exp_fills.size();
    total++;
    if (addr_log.size() - ab !== 2) begin
      bad++;
      $display("FAIL refill_nreq got=%0d want=2", addr_log.size() - ab);
    end else begin
      total++;
      if (addr_log[ab] !== 10'd134) begin bad++; $display("FAIL refill_addr0 got=%0d want=134", addr_log[ab]); end
      total++;
      if (addr_log[ab+1] !== 10'd196) begin bad++; $display("FAIL refill_addr1 got=%0d want=196", addr_log[ab+1]); end
    end
    total++;
    if (fill_q.size() - fb !== 2) begin
      bad++;
      $display("FAIL refill_nfill got=%0d want=2", fill_q.size() - fb);
    end else begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (fill_q[fb+i] !== exp_fills[i]) begin bad++; $display("FAIL refill_fill%0d got=%h want=%h", i, fill_q[fb+i], exp_fills[i]); end
      end
    end
    total++;
    if (rsp_data !== exp_data) begin bad++; $display("FAIL refill_data got=%h want=%h", rsp_data, exp_data); end
    total++;
    if (refill_count !== 16'(exp_count)) begin bad++; $display("FAIL refill_count got=%0d want=%0d", refill_count, exp_count); end
    total++;
    if (addr_bad !== bb) begin bad++; $display("FAIL refill_addr_stable got=%0d want=%0d", addr_bad, bb); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [7:0] cv;
    hit_pat = 8'($urandom_range(0, 255));
    mem_lat = 1;
    model(10, 20);
    do_req(10, 20, lat, cv);
    exp_count += exp_fills.size();
    req_x = 5'd1;
    req_y = 5'd1;
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b want=1", rsp_valid); end
      total++;
      if (rsp_mask !== exp_mask) begin bad++; $display("FAIL bp_mask got=%h want=%h", rsp_mask, exp_mask); end
      total++;
      if (rsp_data !== exp_data) begin bad++; $display("FAIL bp_data got=%h want=%h", rsp_data, exp_data); end
      total++;
      if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready got=%b want=0", req_ready); end
    end
    req_valid = 1'b0;
    finish_rsp();
    @(negedge clk);
    total++;
    if ({rsp_valid, req_ready} !== 2'b01) begin bad++; $display("FAIL bp_after got=%b want=01", {rsp_valid, req_ready}); end
    total++;
    if (refill_count !== 16'(exp_count)) begin bad++; $display("FAIL bp_count got=%0d want=%0d", refill_count, exp_count); end
  endtask

  task automatic test_reset_mid_refill();
    int lat;
    int n;
    int fb;
    logic [7:0] cv;
    hit_pat = 8'h00;
    mem_lat = 6;
    fb = fill_q.size();
    @(negedge clk);
    req_x = 5'd5;
    req_y = 5'd5;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (n = 0; n < 20 && !mem_req; n++) @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL mid_mem_req got=%b want=1", mem_req); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (mem_req !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_req got=%b want=0", mem_req); end
    total++;
    if (refill_count !== 16'h0) begin bad++; $display("FAIL mid_rst_count got=%0d want=0", refill_count); end
    total++;
    if ({req_ready, rsp_valid, cache_write} !== 10'h0) begin bad++; $display("FAIL mid_rst_outs got=%h want=0", {req_ready, rsp_valid, cache_write}); end
    total++;
    if (fill_q.size() !== fb) begin bad++; $display("FAIL mid_rst_fill got=%0d want=%0d", fill_q.size(), fb); end
    rst = 1'b0;
    exp_count = 0;
    hit_pat = 8'hFE;
    mem_lat = 1;
    model(5, 5);
    do_req(5, 5, lat, cv);
    exp_count += exp_fills.size();
    total++;
    if (rsp_data !== exp_data) begin bad++; $display("FAIL mid_after_data got=%h want=%h", rsp_data, exp_data); end
    total++;
    if (refill_count !== 16'(exp_count)) begin bad++; $display("FAIL mid_after_count got=%0d want=%0d", refill_count, exp_count); end
    finish_rsp();
  endtask

  task automatic test_random();
    int lat;
    int fb;
    int ab;
    int x;
    int y;
    logic [7:0] cv;
    spur = 1'b1;
    for (int it = 0; it < 25; it++) begin
      x = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
      y = ($urandom_range(0, 3) == 0) ? 31 : int'($urandom_range(0, 31));
      hit_pat = 8'($urandom_range(0, 255));
      mem_lat = int'($urandom_range(1, 3));
      fb = fill_q.size();
      ab = addr_log.size();
      model(x, y);
      do_req(x, y, lat, cv);
      exp_count += exp_fills.size();
      total++;
      if (rsp_mask !== exp_mask) begin bad++; $display("FAIL rnd_mask it=%0d got=%h want=%h", it, rsp_mask, exp_mask); end
      total++;
      if (rsp_data !== exp_data) begin bad++; $display("FAIL rnd_data it=%0d got=%h want=%h", it, rsp_data, exp_data); end
      total++;
      if (refill_count !== 16'(exp_count)) begin bad++; $display("FAIL rnd_count it=%0d got=%0d want=%0d", it, refill_count, exp_count); end
      total++;
      if (fill_q.size() - fb !== exp_fills.size()) begin
        bad++;
        $display("FAIL rnd_nfill it=%0d got=%0d want=%0d", it, fill_q.size() - fb, exp_fills.size());
      end else begin
        for (int i = 0; i < exp_fills.size(); i++) begin
          total++;
          if (fill_q[fb+i] !== exp_fills[i]) begin bad++; $display("FAIL rnd_fill it=%0d got=%h want=%h", it, fill_q[fb+i], exp_fills[i]); end
        end
      end
      total++;
      if (addr_log.size() - ab !== exp_maddr.size()) begin
        bad++;
        $display("FAIL rnd_nreq it=%0d got=%0d want=%0d", it, addr_log.size() - ab, exp_maddr.size());
      end else begin
        for (int i = 0; i < exp_maddr.size(); i++) begin
          total++;
          if (addr_log[ab+i] !== exp_maddr[i]) begin bad++; $display("FAIL rnd_maddr it=%0d got=%0d want=%0d", it, addr_log[ab+i], exp_maddr[i]); end
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      finish_rsp();
    end
    spur = 1'b0;
    total++;
    if (addr_bad !== 0) begin bad++; $display("FAIL rnd_addr_stable got=%0d want=0", addr_bad); end
  endtask

  initial begin
    test_reset();
    test_all_hit();
    test_corners();
    test_refill();
    test_backpressure();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/neighbor_fetch.md
NEIGHBOR_FETCH -- requirements
Module: neighbor_fetch

Interface
REQ-001 SHALL have parameter X_WIDTH, default 5, meaning grid column bits.
REQ-002 SHALL have parameter Y_WIDTH, default 5, meaning grid row bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default X_WIDTH+Y_WIDTH, meaning node address bits; address = {y, x}.
REQ-004 SHALL have parameter NUM_PORTS, default 8, meaning neighbour slots and cache ports.
REQ-005 SHALL use one clock; reset is synchronous and active-high; ports: clk input 1 (system clock), rst input 1 (synchronous active-high reset).
REQ-006 SHALL have ports: req_valid in 1; req_ready out 1; req_x in X_WIDTH; req_y in Y_WIDTH (centre node request).
REQ-007 SHALL have cache ports: cache_valid out NUM_PORTS; cache_write out NUM_PORTS; cache_addr out ADDR_WIDTH[NUM_PORTS]; cache_wdata out node_mem_t[NUM_PORTS]; cache_hit in NUM_PORTS; cache_rdata in node_mem_t[NUM_PORTS].
REQ-008 SHALL have memory ports: mem_req out 1; mem_addr out ADDR_WIDTH; mem_ack in 1; mem_rdata in node_mem_t.
REQ-009 SHALL have response ports: rsp_valid out 1; rsp_ready in 1; rsp_mask out NUM_PORTS (in-bounds slots); rsp_data out node_mem_t[NUM_PORTS]; refill_count out 16 (saturating refill counter).

Function
REQ-010 SHALL map slots: 0 N(x,y-1), 1 NE(x+1,y-1), 2 E(x+1,y), 3 SE(x+1,y+1), 4 S(x,y+1), 5 SW(x-1,y+1), 6 W(x-1,y), 7 NW(x-1,y-1).
REQ-011 SHALL clear mask bit for any neighbour with coordinate <0 or >2^WIDTH-1; no wrap-around; masked slots never looked up and return data zero.
REQ-012 SHALL implement states IDLE, LOOKUP, WAIT_HIT, REFILL_REQ, REFILL_WAIT, FILL, RESP.
REQ-013 SHALL assert req_ready only in IDLE; req_valid&&req_ready latches coordinates, computes mask/addresses, goes to LOOKUP.
REQ-014 LOOKUP (1 cycle): cache_valid=mask, cache_write=0, cache_addr per slot; -> WAIT_HIT.
REQ-015 WAIT_HIT (1 cycle): capture cache_rdata for slots with mask&cache_hit; miss_vec = mask&~cache_hit; miss_vec==0 -> RESP, else REFILL_REQ.
REQ-016 REFILL_REQ/REFILL_WAIT: select lowest-index set miss_vec bit; hold mem_req=1, mem_addr stable until mem_ack sampled high (ack in first request cycle allowed); capture mem_rdata into that slot; -> FILL.
REQ-017 FILL (1 cycle): drive only that slot's port: cache_valid=1, cache_write=1, addr, wdata=fetched data; clear its miss_vec bit; increment refill_count (saturate at 16'hFFFF); remaining misses -> REFILL_REQ, else RESP.
REQ-018 SHALL keep mem_req low outside REFILL_REQ/REFILL_WAIT; mem_ack outside these ignored.
REQ-019 RESP: rsp_valid=1, rsp_mask/rsp_data stable until rsp_ready; on rsp_valid&&rsp_ready -> IDLE (next request accepted no earlier than following cycle).
REQ-020 All-hit latency SHALL be exactly 3 cycles from acceptance edge to rsp_valid high.
REQ-021 cache_valid/cache_write SHALL be zero in IDLE, REFILL_REQ, REFILL_WAIT, RESP.

Reset
REQ-022 rst SHALL force IDLE next edge, from any state, including mid-refill with mem_req high.
REQ-023 Reset values: req_ready=0 during rst then 1, rsp_valid=0, mem_req=0, cache_valid=0, cache_write=0, rsp_mask=0, rsp_data=0, refill_count=0, miss_vec=0.

Verification
REQ-024 Req (5,5), all cache_hit=1 -> rsp_valid 3 cycles after accept, rsp_mask=8'hFF, data = cache_rdata, refill_count unchanged, mem_req never high.
REQ-025 Req (0,0) -> cache_valid=8'h1C in LOOKUP, rsp_mask=8'h1C; req (31,31) -> rsp_mask=8'hC1; masked data zero.
REQ-026 Req (5,5), misses on slots 1 and 5, mem_ack 2 cycles after mem_req -> mem_addr {4,6} then {6,4}; FILL writes port 1 then port 5; refill_count +=2; rsp data carries memory values.
REQ-027 rsp_ready low 4 cycles in RESP -> rsp_valid, rsp_mask, rsp_data stable; req_ready 0; accept only after handshake.
REQ-028 rst asserted in REFILL_WAIT -> next cycle mem_req=0, state IDLE, refill_count=0, no FILL write; subsequent request completes normally.
